aurora_tx_framer: RTL and testbench

- Frames the 32-bit result stream from the matrix multiplier into Aurora TX user frames (header, payload, trailer).
- Sits directly upstream of the Aurora core's TX AXI4-Stream user interface.
- Buffers results in an internal FIFO.
- Starts a frame only while the lane reports channel_up, so transmission never begins on a link that is down.

---
 rtl/aurora_tx_framer_if.sv | 28 ++
 rtl/aurora_tx_framer.sv | 248 ++++++++++++++++++++++++
 tb/tb_aurora_tx_framer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_tx_framer_if.sv
// Purpose: AXI4-Stream style bundle (tdata/tvalid/tlast/tready) used on both sides of the TX framer.
// Latency: none; this is wiring only.
// Backpressure: tready travels from the slave to the master; the master holds tdata/tlast while tvalid && !tready.
// Ports (modports):
//   master - drives tdata, tvalid, tlast; samples tready
//   slave  - samples tdata, tvalid, tlast; drives tready
interface aurora_tx_framer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/aurora_tx_framer.sv
// Purpose: packs the matrix-multiplier result stream into Aurora TX frames (header, payload, trailer).
// Latency: the header is registered one cycle after the start condition; a frame takes FRAME_LEN+2 cycles at full rate.
// Backpressure: the output holds while tvalid && !tready; upstream stalls when the FIFO is full or during a link-loss flush.
// Ports:
//   clk, peripheral_aresetn - clock and async active-low reset
//   channel_up              - Aurora lane status; frames start only while it is high, and losing it aborts the frame
//   s_axis                  - result stream in (slave)
//   m_axis_tx, m_axis_tx_tkeep - frame stream out to the Aurora TX user port (master)
//   frame_cnt, abort_cnt    - completed-frame count (wraps) and aborted-frame count (saturates)
module aurora_tx_framer #(
    parameter int          DATA_W     = 32,
    parameter int          FRAME_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [15:0] SYNC_WORD  = 16'hA5C3
) (
    input  logic                    clk,
    input  logic                    peripheral_aresetn,
    input  logic                    channel_up,
    aurora_tx_framer_if.slave       s_axis,
    aurora_tx_framer_if.master      m_axis_tx,
    output logic [3:0]              m_axis_tx_tkeep,
    output logic [15:0]             frame_cnt,
    output logic [7:0]              abort_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_TRL
    } state_t;

    state_t state_q, state_d;

    // FIFO storage: each entry is {tlast, tdata}
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     last_pend_q;     // entries in the FIFO that carry tlast

    logic [7:0]        seq_q;
    logic [15:0]       cks_q;
    logic [7:0]        len_q;
    logic [15:0]       frame_cnt_q;
    logic [7:0]        abort_cnt_q;
    logic              rdy_en_q;        // holds s_axis.tready low until the first edge after reset

    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;

    logic              flush;
    logic              fifo_full;
    logic              push;
    logic              tx_hs;
    logic              pop;
    logic              trigger;
    logic [DATA_W-1:0] pay_word;
    logic              pay_last;
    logic [DATA_W-1:0] pay_word_nxt;
    logic [15:0]       cks_upd;
    logic [7:0]        len_upd;
    logic              pay_done;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    // Losing the lane outside IDLE beats any handshake in the same cycle.
    assign flush     = (state_q != ST_IDLE) && !channel_up;
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));

    assign s_axis.tready = rdy_en_q && !fifo_full && !flush;
    assign push          = s_axis.tvalid && s_axis.tready;

    assign tx_hs = tvalid_q && m_axis_tx.tready && channel_up;
    assign pop   = (state_q == ST_PAY) && tx_hs;

    assign rd_ptr_nxt   = rd_ptr_q + 1'b1;
    assign pay_word     = mem_q[rd_ptr_q][DATA_W-1:0];
    assign pay_last     = mem_q[rd_ptr_q][DATA_W];
    // Output is registered, so the word after the head is preloaded when the head is accepted.
    // The start condition guarantees it is already in the FIFO.
    assign pay_word_nxt = mem_q[rd_ptr_nxt][DATA_W-1:0];

    assign cks_upd  = cks_q ^ pay_word[31:16] ^ pay_word[15:0];
    assign len_upd  = len_q + 8'd1;
    assign pay_done = pay_last || (len_upd == 8'(FRAME_LEN));

    assign trigger = channel_up && ((count_q >= CW'(FRAME_LEN)) || (last_pend_q != '0));

    // ------------------------------------------------------------------
    // FSM: state register (also holds the registered output stage)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (trigger)               state_d = ST_HDR;
            ST_HDR:  if (flush)                 state_d = ST_IDLE;
                     else if (tx_hs)            state_d = ST_PAY;
            ST_PAY:  if (flush)                 state_d = ST_IDLE;
                     else if (tx_hs && pay_done) state_d = ST_TRL;
            ST_TRL:  if (flush || tx_hs)        state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output stage; loads the word for the state being entered, holds on stall
    // ------------------------------------------------------------------
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (flush) begin
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        tdata_d  = {SYNC_WORD, seq_q, 8'h00};
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b0;
                    end
                end
                ST_HDR: begin
                    if (tx_hs) begin
                        tdata_d = pay_word;
                        tlast_d = 1'b0;
                    end
                end
                ST_PAY: begin
                    if (tx_hs) begin
                        if (pay_done) begin
                            tdata_d = {len_upd, seq_q, cks_upd};
                            tlast_d = 1'b1;
                        end else begin
                            tdata_d = pay_word_nxt;
                            tlast_d = 1'b0;
                        end
                    end
                end
                ST_TRL: begin
                    if (tx_hs) begin
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end
                end
                default: begin
                    tdata_d  = '0;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_pend_q <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (flush) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                last_pend_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_nxt;
                count_q     <= count_q + CW'(push) - CW'(pop);
                last_pend_q <= last_pend_q + CW'(push & s_axis.tlast) - CW'(pop & pay_last);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame accounting: checksum, length, sequence, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            seq_q       <= '0;
            cks_q       <= '0;
            len_q       <= '0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && trigger) begin
                cks_q <= '0;
                len_q <= '0;
            end
            if (pop) begin
                cks_q <= cks_upd;
                len_q <= len_upd;
            end
            if ((state_q == ST_TRL) && tx_hs) begin
                seq_q       <= seq_q + 8'd1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (flush && (abort_cnt_q != 8'hFF)) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end
    end

    assign m_axis_tx.tdata  = tdata_q;
    assign m_axis_tx.tvalid = tvalid_q;
    assign m_axis_tx.tlast  = tlast_q;
    assign m_axis_tx_tkeep  = 4'hF;
    assign frame_cnt        = frame_cnt_q;
    assign abort_cnt        = abort_cnt_q;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Purpose: randomized bench for aurora_tx_framer against a frame-level reference model.
// Latency: inputs driven #1 after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised through fixed, toggling and random m_axis_tx tready patterns.
module tb_aurora_tx_framer;

    localparam int FL    = 16;
    localparam int DEPTH = 32;

    logic        clk;
    logic        peripheral_aresetn;
    logic        channel_up;
    logic [3:0]  m_axis_tx_tkeep;
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;

    aurora_tx_framer_if #(.DATA_W(32)) s_if ();
    aurora_tx_framer_if #(.DATA_W(32)) m_if ();

    aurora_tx_framer #(
        .DATA_W(32), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .SYNC_WORD(16'hA5C3)
    ) dut (
        .clk                (clk),
        .peripheral_aresetn (peripheral_aresetn),
        .channel_up         (channel_up),
        .s_axis             (s_if),
        .m_axis_tx          (m_if),
        .m_axis_tx_tkeep    (m_axis_tx_tkeep),
        .frame_cnt          (frame_cnt),
        .abort_cnt          (abort_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [32:0] src_q[$];   // words waiting to be offered upstream
    logic [32:0] in_q[$];    // words accepted and not yet sent in a completed frame
    logic [32:0] exp_f[$];   // expected words of the frame in flight, {tlast, tdata}
    int          popped;     // payload words of the current frame already sent
    int          n_pay;
    int          idx;
    bit          in_frame;
    logic [7:0]  m_seq;
    logic [15:0] m_frames;
    logic [7:0]  m_aborts;
    bit          prev_idle, prev_trig, prev_gap, prev_stall;
    logic [33:0] prev_out;
    int          cyc;
    int          acc_cnt;
    logic [31:0] cap_hdr, cap_trl;
    int          cap_hdr_cyc, cap_trl_cyc;
    int          rdy_mode;   // 0: always ready, 1: toggle, 2: random
    bit          gap_en;

    function automatic bit has_last();
        foreach (in_q[i]) if (in_q[i][32]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        in_q.delete();
        exp_f.delete();
        popped = 0; in_frame = 0; idx = 0; n_pay = 0;
        m_seq = '0; m_frames = '0; m_aborts = '0;
        prev_idle = 1'b1; prev_trig = 1'b0; prev_gap = 1'b0; prev_stall = 1'b0;
        prev_out = '0;
    endtask

    // Expected frame built from the buffered words using the framing rules.
    task automatic build_frame();
        logic [15:0] cks;
        logic [7:0]  n8;
        int n;
        exp_f.delete();
        cks = '0;
        n = 0;
        exp_f.push_back({1'b0, 16'hA5C3, m_seq, 8'h00});
        while (n < in_q.size() && n < FL) begin
            exp_f.push_back({1'b0, in_q[n][31:0]});
            cks = cks ^ in_q[n][31:16] ^ in_q[n][15:0];
            n++;
            if (in_q[n-1][32]) break;
        end
        n8 = n[7:0];
        exp_f.push_back({1'b1, n8, m_seq, cks});
        n_pay = n;
        idx = 0;
    endtask

    task automatic handle_out();
        logic [32:0] dummy;
        if (!in_frame) begin
            build_frame();
            in_frame = 1'b1;
        end
        if (idx < exp_f.size()) chk($sformatf("tx_word%0d", idx), {m_if.tlast, m_if.tdata}, exp_f[idx]);
        else                    chk("tx_overrun", idx, exp_f.size());
        if (idx == 0) begin cap_hdr = m_if.tdata; cap_hdr_cyc = cyc; end
        if (m_if.tlast) begin cap_trl = m_if.tdata; cap_trl_cyc = cyc; end
        if (idx >= 1 && idx <= n_pay) popped++;
        idx++;
        if (idx >= exp_f.size()) begin
            for (int k = 0; k < n_pay; k++) dummy = in_q.pop_front();
            popped   = 0;
            in_frame = 1'b0;
            m_seq    = m_seq + 8'd1;
            m_frames = m_frames + 16'd1;
        end
    endtask

    task automatic sample();
        bit flush_now, in_hs, out_hs;
        int fifo_cnt;
        cyc++;
        chk("frame_cnt", frame_cnt, m_frames);
        chk("abort_cnt", abort_cnt, m_aborts);
        chk("tkeep", m_axis_tx_tkeep, 4'hF);
        fifo_cnt  = in_q.size() - popped;
        flush_now = !channel_up && m_if.tvalid;
        if (prev_idle)  chk("start", m_if.tvalid, prev_trig);
        if (prev_gap)   chk("gap_vld", m_if.tvalid, 1'b0);
        if (prev_stall) chk("stall_out", {m_if.tvalid, m_if.tlast, m_if.tdata}, prev_out);
        chk("s_tready", s_if.tready, (fifo_cnt < DEPTH) && !flush_now);
        in_hs  = s_if.tvalid && s_if.tready;
        out_hs = m_if.tvalid && m_if.tready && channel_up;
        prev_idle  = !m_if.tvalid;
        prev_trig  = channel_up && (fifo_cnt >= FL || has_last());
        prev_gap   = flush_now || (out_hs && m_if.tlast);
        prev_stall = m_if.tvalid && !m_if.tready && channel_up;
        prev_out   = {m_if.tvalid, m_if.tlast, m_if.tdata};
        if (in_hs) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        if (flush_now) begin
            in_q.delete();
            popped   = 0;
            in_frame = 1'b0;
            if (m_aborts != 8'hFF) m_aborts = m_aborts + 8'd1;
        end else begin
            if (out_hs) handle_out();
            if (in_hs)  in_q.push_back({s_if.tlast, s_if.tdata});
        end
    endtask

    task automatic cycle();
        if (src_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = src_q[0][31:0];
            s_if.tlast  = src_q[0][32];
        end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = $urandom;
            s_if.tlast  = 1'b0;
        end
        case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = ~m_if.tready;
            default: m_if.tready = 1'($urandom_range(1));
        endcase
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (src_q.size() == 0 && in_q.size() == 0 && !in_frame && !m_if.tvalid) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        chk("drain", done, 1'b1);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        peripheral_aresetn = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        src_q.delete();
        model_reset();
        #2;
        chk("rst_tvalid", m_if.tvalid, 1'b0);
        chk("rst_tlast",  m_if.tlast,  1'b0);
        chk("rst_tdata",  m_if.tdata,  32'h0);
        chk("rst_tkeep",  m_axis_tx_tkeep, 4'hF);
        chk("rst_sready", s_if.tready, 1'b0);
        chk("rst_frames", frame_cnt, 16'h0);
        chk("rst_aborts", abort_cnt, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        peripheral_aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_popped(input int n, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_frame && popped == n) begin hit = 1'b1; break; end
            cycle();
        end
        chk(tag, hit, 1'b1);
    endtask

    initial begin
        logic [7:0]  seq_before;
        logic [15:0] frames_before;
        int          down_cnt;
        cyc = 0; acc_cnt = 0; rdy_mode = 0; gap_en = 1'b0;
        cap_hdr = '0; cap_trl = '0; cap_hdr_cyc = 0; cap_trl_cyc = 0;
        channel_up = 1'b1;
        do_reset();

        // Full 16-word frame
        for (int i = 1; i <= 16; i++) src_q.push_back({1'b0, 32'(i)});
        wait_idle(200);
        chk("s1_hdr",    cap_hdr, 32'hA5C30000);
        chk("s1_trl",    cap_trl, 32'h10000010);
        chk("s1_span",   cap_trl_cyc - cap_hdr_cyc, FL + 1);
        chk("s1_frames", frame_cnt, 16'd1);

        // Short frame closed by tlast
        src_q.push_back({1'b0, 32'hFFFF0000});
        src_q.push_back({1'b0, 32'h00001234});
        src_q.push_back({1'b1, 32'h0000000F});
        wait_idle(200);
        chk("s2_hdr", cap_hdr, 32'hA5C30100);
        chk("s2_trl", cap_trl, 32'h0301EDC4);

        // Toggling tready across a full frame
        rdy_mode = 1;
        for (int i = 1; i <= 16; i++) src_q.push_back({1'b0, 32'(i)});
        wait_idle(300);
        rdy_mode = 0;
        chk("s3_hdr", cap_hdr, 32'hA5C30200);
        chk("s3_trl", cap_trl, 32'h10020010);

        // Link down: FIFO fills to 32, nothing is sent; then drains as 16+16+8
        channel_up = 1'b0;
        frames_before = m_frames;
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) src_q.push_back({(i == 39), $urandom});
        repeat (60) cycle();
        chk("s4_acc32", acc_cnt, 32);
        chk("s4_novld", m_if.tvalid, 1'b0);
        channel_up = 1'b1;
        wait_idle(400);
        chk("s4_frames", frame_cnt, frames_before + 16'd3);

        // Lane lost after 5 payload handshakes
        seq_before    = m_seq;
        frames_before = m_frames;
        for (int i = 0; i < 20; i++) src_q.push_back({1'b0, $urandom});
        wait_popped(5, "s5_reach");
        channel_up = 1'b0;
        cycle();
        channel_up = 1'b1;
        cycle();
        chk("s5_vld",    m_if.tvalid, 1'b0);
        chk("s5_abort",  abort_cnt, 8'd1);
        chk("s5_frames", frame_cnt, frames_before);
        repeat (4) cycle();
        for (int i = 0; i < 16; i++) src_q.push_back({1'b0, $urandom});
        wait_idle(300);
        chk("s5_seq", cap_hdr[15:8], seq_before);

        // Random traffic, random tready, occasional lane drops
        rdy_mode = 2;
        gap_en   = 1'b1;
        down_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            if (src_q.size() < 4) src_q.push_back({($urandom_range(7) == 0), $urandom});
            if (down_cnt > 0) begin
                channel_up = 1'b0;
                down_cnt--;
            end else begin
                channel_up = 1'b1;
                if ($urandom_range(63) == 0) down_cnt = $urandom_range(3, 1);
            end
            cycle();
        end
        channel_up = 1'b1;
        rdy_mode   = 0;
        gap_en     = 1'b0;
        src_q.push_back({1'b1, $urandom});
        wait_idle(1000);

        // Async reset in the middle of the payload
        for (int i = 0; i < 16; i++) src_q.push_back({1'b0, $urandom});
        wait_popped(3, "s6_reach");
        #3;
        peripheral_aresetn = 1'b0;
        #1;
        chk("ar_tvalid", m_if.tvalid, 1'b0);
        chk("ar_tlast",  m_if.tlast,  1'b0);
        chk("ar_tdata",  m_if.tdata,  32'h0);
        chk("ar_sready", s_if.tready, 1'b0);
        chk("ar_frames", frame_cnt, 16'h0);
        chk("ar_aborts", abort_cnt, 8'h0);
        s_if.tvalid = 1'b0;
        src_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        peripheral_aresetn = 1'b1;
        @(posedge clk);
        #1;
        src_q.push_back({1'b0, 32'h0000ABCD});
        src_q.push_back({1'b1, 32'h12340000});
        wait_idle(200);
        chk("ar_hdr", cap_hdr, 32'hA5C30000);
        chk("ar_trl", cap_trl, 32'h0200B9F9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
